// File: rtl/conv_code_pkg.sv
// Shared constants and helpers for the K=3, rate-1/2 (7,5) convolutional code.
package conv_code_pkg;

  // Code definition: constraint length and octal generator polynomials.
  // Tap order in the generator masks is {u, s[1], s[0]}.
  localparam int         K      = 3;
  localparam logic [2:0] GEN_C0 = 3'o7;
  localparam logic [2:0] GEN_C1 = 3'o5;

  // Trellis size and encoder state indices, where state = {u[n-1], u[n-2]}.
  localparam int         NUM_STATES = 1 << (K - 1);
  localparam logic [1:0] ST_00      = 2'd0;
  localparam logic [1:0] ST_01      = 2'd1;
  localparam logic [1:0] ST_10      = 2'd2;
  localparam logic [1:0] ST_11      = 2'd3;

  // Decoder defaults.
  localparam int TB_DEPTH_DEFAULT = 16;
  localparam int PM_W_DEFAULT     = 4;

  // After reset, the decoder starts with state 0 favoured.
  // States 1..3 start penalised by this metric.
  localparam int PM_RESET_OTHER = 4;

  typedef logic [1:0] state_t;
  typedef logic [1:0] symbol_t;

  // Returns the encoder output {c0, c1} for input bit u in state s.
  function automatic symbol_t encodeSymbol(input state_t s, input logic u);
    logic [2:0] taps;
    taps = {u, s};
    return {^(taps & GEN_C0), ^(taps & GEN_C1)};
  endfunction

  // Returns the Hamming distance between a received hard symbol and an
  // expected one.
  function automatic logic [1:0] branchMetric(input symbol_t rx, input symbol_t expSym);
    logic [1:0] diff;
    diff = rx ^ expSym;
    return {1'b0, diff[1]} + {1'b0, diff[0]};
  endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select cell for one trellis state.
// Candidate 0 always comes from the lower-index predecessor, so a tie keeps
// candidate 0. The sum is one bit wider than a path metric, which lets the
// un-normalised value never wrap.
module viterbi_acs
  import conv_code_pkg::*;
#(
  parameter int PM_W = PM_W_DEFAULT
) (
  input  logic [PM_W-1:0] pm0_i,
  input  logic [PM_W-1:0] pm1_i,
  input  logic [1:0]      bm0_i,
  input  logic [1:0]      bm1_i,
  output logic [PM_W:0]   sum_o,
  output logic            sel_o
);

  logic [PM_W:0] cand0;
  logic [PM_W:0] cand1;

  // Add both branch metrics.
  // Keep the strictly smaller candidate; ties resolve toward predecessor 0.
  always_comb begin
    cand0 = {1'b0, pm0_i} + (PM_W + 1)'(bm0_i);
    cand1 = {1'b0, pm1_i} + (PM_W + 1)'(bm1_i);
    sel_o = (cand1 < cand0);
    sum_o = sel_o ? cand1 : cand0;
  end

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder for the K=3, rate-1/2 (7,5) code.
// Survivors use register exchange.
// Each accepted symbol emits the oldest bit of the best state's survivor one
// cycle later, after the survivor pipeline has filled.
module viterbi_decoder
  import conv_code_pkg::*;
#(
  parameter int TB_DEPTH = TB_DEPTH_DEFAULT,
  parameter int PM_W     = PM_W_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] din,
  input  logic       din_valid,
  output logic       dout,
  output logic       dout_valid
);

  localparam int                 CNT_W      = $clog2(TB_DEPTH + 1);
  localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(TB_DEPTH);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(TB_DEPTH - 1);
  localparam logic [PM_W-1:0]    PM_PENALTY = PM_W'(PM_RESET_OTHER);

  // Architectural state.
  logic [NUM_STATES-1:0][PM_W-1:0]     pm_q;
  logic [NUM_STATES-1:0][PM_W-1:0]     pm_d;
  logic [NUM_STATES-1:0][TB_DEPTH-1:0] surv_q;
  logic [NUM_STATES-1:0][TB_DEPTH-1:0] surv_d;
  logic [CNT_W-1:0]                    cnt_q;
  logic [CNT_W-1:0]                    cnt_d;
  logic                                dout_q;
  logic                                dout_d;
  logic                                doutValid_q;
  logic                                doutValid_d;

  // Per-state results of the trellis step for the current input symbol.
  logic [PM_W:0]                       acsSum  [NUM_STATES];
  logic                                acsSel  [NUM_STATES];
  logic [TB_DEPTH-1:0]                 survNew [NUM_STATES];
  logic [PM_W-1:0]                     pmNorm  [NUM_STATES];
  logic [PM_W:0]                       minSum;
  state_t                              bestIdx;

  // One ACS cell per new state ns = {u, a}.
  // Its predecessors are {a,0} and {a,1}, and each is reached with input bit u.
  for (genvar ns = 0; ns < NUM_STATES; ns++) begin : g_state
    localparam int     A_BIT = ns % 2;
    localparam int     PRED0 = 2 * A_BIT;
    localparam int     PRED1 = 2 * A_BIT + 1;
    localparam logic   U_BIT = 1'(ns / 2);

    logic [1:0] bm0;
    logic [1:0] bm1;

    assign bm0 = branchMetric(din, encodeSymbol(state_t'(PRED0), U_BIT));
    assign bm1 = branchMetric(din, encodeSymbol(state_t'(PRED1), U_BIT));

    viterbi_acs #(
      .PM_W (PM_W)
    ) u_acs (
      .pm0_i (pm_q[PRED0]),
      .pm1_i (pm_q[PRED1]),
      .bm0_i (bm0),
      .bm1_i (bm1),
      .sum_o (acsSum[ns]),
      .sel_o (acsSel[ns])
    );

    assign survNew[ns] = acsSel[ns]
                       ? {surv_q[PRED1][TB_DEPTH-2:0], U_BIT}
                       : {surv_q[PRED0][TB_DEPTH-2:0], U_BIT};
  end

  // Find the minimum new metric and the lowest-index state that holds it.
  // Then subtract that minimum from every metric, so the best state sits at 0.
  always_comb begin
    minSum  = acsSum[0];
    bestIdx = ST_00;
    for (int i = 1; i < NUM_STATES; i++) begin
      if (acsSum[i] < minSum) begin
        minSum  = acsSum[i];
        bestIdx = state_t'(i);
      end
    end
    for (int i = 0; i < NUM_STATES; i++) begin
      pmNorm[i] = PM_W'(acsSum[i] - minSum);
    end
  end

  // Next-state logic.
  // State advances only on an accepted symbol; idle cycles hold everything
  // and drop dout_valid.
  always_comb begin
    pm_d        = pm_q;
    surv_d      = surv_q;
    cnt_d       = cnt_q;
    dout_d      = dout_q;
    doutValid_d = 1'b0;
    if (din_valid) begin
      for (int i = 0; i < NUM_STATES; i++) begin
        pm_d[i]   = pmNorm[i];
        surv_d[i] = survNew[i];
      end
      if (cnt_q != CNT_FULL) begin
        cnt_d = cnt_q + 1'b1;
      end
      dout_d      = survNew[bestIdx][TB_DEPTH-1];
      doutValid_d = (cnt_q >= CNT_LAST);
    end
  end

  // State register.
  // Reset wins over din_valid and restarts the trellis with state 0 favoured.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_STATES; i++) begin
        pm_q[i]   <= (i == 0) ? '0 : PM_PENALTY;
        surv_q[i] <= '0;
      end
      cnt_q       <= '0;
      dout_q      <= 1'b0;
      doutValid_q <= 1'b0;
    end else begin
      pm_q        <= pm_d;
      surv_q      <= surv_d;
      cnt_q       <= cnt_d;
      dout_q      <= dout_d;
      doutValid_q <= doutValid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = doutValid_q;

endmodule

// File: tb/tb_viterbi_decoder.sv
// Directed self-checking bench for viterbi_decoder.
// Outputs are sampled 1 ns after each rising clock edge.
module tb_viterbi_decoder;

  logic       clk;
  logic       rst;
  logic [1:0] din;
  logic       din_valid;
  logic       dout;
  logic       dout_valid;

  int errCount;
  int checkCount;

  // Hand-encoded reference stream, starting from state 0.
  // infoBits[n] is the information bit and codeSyms[n] is its {c0,c1} symbol.
  logic       infoBits [36] = '{1,1,1,0,1,1,0,0,0,0,0,1,0,1,1,1,0,1,
                                1,1,1,1,0,0,0,1,1,1,0,1,0,0,0,1,1,1};
  logic [1:0] codeSyms [36] = '{2'b11,2'b01,2'b10,2'b01,2'b00,2'b01,2'b01,2'b11,2'b00,
                                2'b00,2'b00,2'b11,2'b10,2'b00,2'b01,2'b10,2'b01,2'b00,
                                2'b01,2'b10,2'b10,2'b10,2'b01,2'b11,2'b00,2'b11,2'b01,
                                2'b10,2'b01,2'b00,2'b10,2'b11,2'b00,2'b11,2'b01,2'b10};

  viterbi_decoder #(
    .TB_DEPTH (16),
    .PM_W     (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of input.
  // On return, the outputs produced by that edge are visible.
  task automatic tick(input logic v, input logic [1:0] sym);
    din       = sym;
    din_valid = v;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din       = 2'b00;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick(1'b0, 2'b00);
    rst = 1'b0;
  endtask

  // Reference encoder used to generate the random stream.
  function automatic logic [1:0] refEncode(input logic [1:0] s, input logic u);
    return {u ^ s[1] ^ s[0], u ^ s[0]};
  endfunction

  task automatic test_reset();
    $display("[TB] test_reset");
    rst = 1'b1;
    tick(1'b1, 2'b11);
    tick(1'b1, 2'b10);
    checkCount++;
    if (dut.pm_q[0] !== 4'd0) begin
      errCount++;
      $display("[TB] FAIL reset_pm0: got %0d expected 0", dut.pm_q[0]);
    end
    for (int k = 1; k < 4; k++) begin
      checkCount++;
      if (dut.pm_q[k] !== 4'd4) begin
        errCount++;
        $display("[TB] FAIL reset_pm%0d: got %0d expected 4", k, dut.pm_q[k]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      checkCount++;
      if (dut.surv_q[k] !== 16'h0000) begin
        errCount++;
        $display("[TB] FAIL reset_surv%0d: got %h expected 0000", k, dut.surv_q[k]);
      end
    end
    checkCount++;
    if (dout !== 1'b0 || dout_valid !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL reset_outputs: got dout=%b valid=%b expected 0 0", dout, dout_valid);
    end
    rst = 1'b0;
    tick(1'b0, 2'b11);
    checkCount++;
    if (dout_valid !== 1'b0 || dut.pm_q[1] !== 4'd4 || dut.pm_q[0] !== 4'd0) begin
      errCount++;
      $display("[TB] FAIL idle_hold: got valid=%b pm0=%0d pm1=%0d expected 0 0 4",
               dout_valid, dut.pm_q[0], dut.pm_q[1]);
    end
  endtask

  task automatic test_zero_stream();
    int pulses;
    $display("[TB] test_zero_stream");
    doReset();
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 2'b00);
      checkCount++;
      if (dout_valid !== (i >= 15)) begin
        errCount++;
        $display("[TB] FAIL zero_valid[%0d]: got %b expected %b", i, dout_valid, (i >= 15));
      end
      checkCount++;
      if (dout !== 1'b0) begin
        errCount++;
        $display("[TB] FAIL zero_dout[%0d]: got %b expected 0", i, dout);
      end
      if (dout_valid === 1'b1) pulses++;
    end
    checkCount++;
    if (pulses != 5) begin
      errCount++;
      $display("[TB] FAIL zero_pulses: got %0d expected 5", pulses);
    end
  endtask

  task automatic test_error_free();
    int outIdx;
    $display("[TB] test_error_free");
    doReset();
    outIdx = 0;
    for (int i = 0; i < 36; i++) begin
      tick(1'b1, codeSyms[i]);
      checkCount++;
      if (dout_valid !== (i >= 15)) begin
        errCount++;
        $display("[TB] FAIL clean_valid[%0d]: got %b expected %b", i, dout_valid, (i >= 15));
      end
      if (dout_valid === 1'b1 && outIdx < 36) begin
        checkCount++;
        if (dout !== infoBits[outIdx]) begin
          errCount++;
          $display("[TB] FAIL clean_bit[%0d]: got %b expected %b", outIdx, dout, infoBits[outIdx]);
        end
        outIdx++;
      end
    end
    checkCount++;
    if (outIdx != 21) begin
      errCount++;
      $display("[TB] FAIL clean_count: got %0d expected 21", outIdx);
    end
  endtask

  task automatic test_single_error();
    int outIdx;
    logic [1:0] sym;
    $display("[TB] test_single_error");
    doReset();
    outIdx = 0;
    for (int i = 0; i < 36; i++) begin
      sym = codeSyms[i];
      if (i == 5) sym = sym ^ 2'b01;
      tick(1'b1, sym);
      for (int k = 0; k < 4; k++) begin
        checkCount++;
        if (dut.pm_q[k] > 4'd6) begin
          errCount++;
          $display("[TB] FAIL err1_pm%0d[%0d]: got %0d expected <=6", k, i, dut.pm_q[k]);
        end
      end
      if (dout_valid === 1'b1 && outIdx < 36) begin
        checkCount++;
        if (dout !== infoBits[outIdx]) begin
          errCount++;
          $display("[TB] FAIL err1_bit[%0d]: got %b expected %b", outIdx, dout, infoBits[outIdx]);
        end
        outIdx++;
      end
    end
    checkCount++;
    if (outIdx != 21) begin
      errCount++;
      $display("[TB] FAIL err1_count: got %0d expected 21", outIdx);
    end
  endtask

  task automatic test_sparse_valid();
    int   outIdx;
    logic lastExp;
    $display("[TB] test_sparse_valid");
    doReset();
    outIdx  = 0;
    lastExp = 1'b0;
    for (int i = 0; i < 36; i++) begin
      tick(1'b1, codeSyms[i]);
      checkCount++;
      if (dout_valid !== (i >= 15)) begin
        errCount++;
        $display("[TB] FAIL sparse_valid[%0d]: got %b expected %b", i, dout_valid, (i >= 15));
      end
      if (dout_valid === 1'b1 && outIdx < 36) begin
        lastExp = infoBits[outIdx];
        checkCount++;
        if (dout !== lastExp) begin
          errCount++;
          $display("[TB] FAIL sparse_bit[%0d]: got %b expected %b", outIdx, dout, lastExp);
        end
        outIdx++;
      end
      for (int g = 0; g < 2; g++) begin
        tick(1'b0, ~codeSyms[i]);
        checkCount++;
        if (dout_valid !== 1'b0 || dout !== lastExp) begin
          errCount++;
          $display("[TB] FAIL sparse_idle[%0d]: got valid=%b dout=%b expected 0 %b",
                   i, dout_valid, dout, lastExp);
        end
      end
    end
    checkCount++;
    if (outIdx != 21) begin
      errCount++;
      $display("[TB] FAIL sparse_count: got %0d expected 21", outIdx);
    end
  endtask

  task automatic test_reset_midstream();
    $display("[TB] test_reset_midstream");
    doReset();
    for (int i = 0; i < 10; i++) tick(1'b1, codeSyms[i]);
    rst = 1'b1;
    tick(1'b1, 2'b11);
    rst = 1'b0;
    checkCount++;
    if (dout_valid !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL midrst_valid: got %b expected 0", dout_valid);
    end
    checkCount++;
    if (dut.pm_q[0] !== 4'd0 || dut.pm_q[3] !== 4'd4) begin
      errCount++;
      $display("[TB] FAIL midrst_pm: got pm0=%0d pm3=%0d expected 0 4", dut.pm_q[0], dut.pm_q[3]);
    end
    for (int j = 0; j < 18; j++) begin
      tick(1'b1, codeSyms[j]);
      checkCount++;
      if (dout_valid !== (j >= 15)) begin
        errCount++;
        $display("[TB] FAIL midrst_valid[%0d]: got %b expected %b", j, dout_valid, (j >= 15));
      end
      if (j >= 15) begin
        checkCount++;
        if (dout !== infoBits[j - 15]) begin
          errCount++;
          $display("[TB] FAIL midrst_bit[%0d]: got %b expected %b", j - 15, dout, infoBits[j - 15]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic       expQ [$];
    logic [1:0] encState;
    logic [1:0] sym;
    logic       u;
    logic       expBit;
    logic [3:0] minPm;
    int         outs;
    $display("[TB] test_random");
    doReset();
    encState = 2'b00;
    outs     = 0;
    for (int n = 0; n < 500; n++) begin
      u        = 1'($urandom_range(0, 1));
      sym      = refEncode(encState, u);
      encState = {u, encState[1]};
      if (n % 8 == 7) sym = sym ^ (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10);
      expQ.push_back(u);
      tick(1'b1, sym);
      minPm = 4'hF;
      for (int k = 0; k < 4; k++) begin
        if (dut.pm_q[k] < minPm) minPm = dut.pm_q[k];
      end
      checkCount++;
      if (minPm !== 4'd0) begin
        errCount++;
        $display("[TB] FAIL rand_minpm[%0d]: got %0d expected 0", n, minPm);
      end
      if (dout_valid === 1'b1) begin
        expBit = (expQ.size() > 0) ? expQ.pop_front() : 1'bx;
        checkCount++;
        if (dout !== expBit) begin
          errCount++;
          $display("[TB] FAIL rand_bit[%0d]: got %b expected %b", outs, dout, expBit);
        end
        outs++;
      end
    end
    checkCount++;
    if (outs != 485) begin
      errCount++;
      $display("[TB] FAIL rand_count: got %0d expected 485", outs);
    end
  endtask

  // Run every scenario in sequence, then report.
  initial begin
    errCount   = 0;
    checkCount = 0;
    rst        = 1'b0;
    din        = 2'b00;
    din_valid  = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_zero_stream();
    test_error_free();
    test_single_error();
    test_sparse_valid();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/viterbi_decoder.md
VITERBI_DECODER -- requirements
Module: viterbi_decoder

Interface
REQ-001 SHALL have parameter TB_DEPTH, default 16, meaning survivor length and decode latency in accepted symbols.
REQ-002 SHALL have parameter PM_W, default 4, meaning path-metric width in bits.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit, meaning reset; synchronous, active-high.
REQ-005 SHALL have port din, input, 2 bits, meaning hard-decision code symbol: din[1] = c0 (g=7 octal), din[0] = c1 (g=5 octal).
REQ-006 SHALL have port din_valid, input, 1 bit, meaning din is accepted on this edge; the block has no backpressure.
REQ-007 SHALL have port dout, output, 1 bit, meaning decoded information bit.
REQ-008 SHALL have port dout_valid, output, 1 bit, meaning dout is valid for exactly this cycle.

Function
REQ-009 SHALL decode the K=3, rate-1/2 code with encoder state s = {u[n-1], u[n-2]}: c0 = u^s[1]^s[0], c1 = u^s[0], next state = {u, s[1]}.
REQ-010 SHALL compute each branch metric as the Hamming distance (0..2) between din and the expected {c0, c1}.
REQ-011 SHALL form new state ns = {u, a} from the two predecessors {a,0} and {a,1} by add-compare-select.
REQ-012 SHALL break ACS ties by selecting the lower-index predecessor.
REQ-013 SHALL normalise the path metrics on every accepted symbol by subtracting the minimum new metric from all four, keeping every metric within 0..6 so that PM_W=4 never overflows.
REQ-014 SHALL use register exchange for the survivors: new_surv[ns] = {surv[sel_pred][TB_DEPTH-2:0], u}.
REQ-015 SHALL, on the cycle after each accepted symbol, drive dout = surv[best][TB_DEPTH-1], where best is the minimum-metric state (lowest index on a tie).
REQ-016 SHALL count accepted symbols with a counter that saturates at TB_DEPTH.
REQ-017 SHALL assert dout_valid for one cycle after each accepted symbol once that count reaches TB_DEPTH; the first output is the bit of symbol 0, emitted after symbol TB_DEPTH-1.
REQ-018 SHALL leave metrics, survivors, counter and dout unchanged, with dout_valid=0, on every cycle with din_valid=0.
REQ-019 SHALL have no flush or tail handling; the final TB_DEPTH-1 bits stay inside the block until further symbols arrive.

Reset
REQ-020 SHALL, on any edge with rst=1, set the metric of state 0 to 0 and of states 1..3 to 4.
REQ-021 SHALL, on the same edge, clear all survivors and the counter, and set dout=0 and dout_valid=0.
REQ-022 SHALL ignore din and din_valid while rst=1.
REQ-023 SHALL give reset priority over a simultaneous din_valid.
REQ-024 SHALL, after a reset asserted mid-stream, restart with the full TB_DEPTH latency before the next dout_valid.

Structure
REQ-025 SHALL take K, the generator constants (7, 5), the default TB_DEPTH and PM_W, and the state-index constants from a shared package, conv_code_pkg.
REQ-026 SHALL implement ACS as sub-module viterbi_acs: two metrics and two branch metrics in, normalised-ready sum and select bit out; four instances.
REQ-027 SHALL be entirely synchronous to clk, with no latches and no combinational path from din to dout.

Verification
REQ-028 SHALL cover: 20 symbols din=00 with din_valid held high -> first dout_valid on the cycle after symbol 15, then 5 pulses, all dout=0.
REQ-029 SHALL cover: the info bits 1,1,1,0,1,1,0,0,0,0,0,1,0,1,1,1,0,1,1,1,1,1,0,0,0,1,1,1,0,1,0,0,0,1,1,1 encoded from state 0 (first symbol 11), error-free -> the first 21 bits are reproduced exactly, in order.
REQ-030 SHALL cover: the same stream with symbol 5 inverted in one bit -> identical decoded output, and all metrics stay at or below 6.
REQ-031 SHALL cover: the same stream with din_valid high every third cycle only -> identical output sequence, each dout_valid exactly 1 cycle after its accepted symbol.
REQ-032 SHALL cover: rst pulsed for 1 cycle after 10 symbols, then a new stream applied -> dout_valid=0 on the cycle after the pulse, and the first new output appears only after 16 new symbols.
REQ-033 SHALL cover: 500 random encoded symbols with one bit error every 8th symbol -> zero decoded errors, and the minimum metric is 0 after every update.
